// File: rtl/afisor_7seg_mux.sv
// Time-multiplexed common-anode 7-segment driver: shadow/display double buffer with
// frame-synchronous swap, guard slot per digit, optional hex glyphs and leading-zero blanking.
module afisor_7seg_mux #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          HEX_EN   = 1'b0,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp,
    input  logic                enable,
    output logic [6:0]          seg_n,
    output logic                dp_n,
    output logic [DIGITS-1:0]   an_n,
    output logic                frame_done
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VW = 4 * DIGITS;
    localparam logic [PW-1:0] PMax   = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IdxMax = IW'(DIGITS - 1);

    logic [PW-1:0]     p_q, p_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [VW-1:0]     shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [VW-1:0]     disp_val_q, disp_val_d;
    logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [6:0]        seg_n_q, seg_n_d;
    logic              dp_n_q, dp_n_d;
    logic [DIGITS-1:0] an_n_q, an_n_d;
    logic              frame_done_q, frame_done_d;

    logic              p_last;
    logic              idx_last;
    logic              boundary;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;
    logic [DIGITS-1:0] an_sel;
    logic              lit;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = HEX_EN ? 7'b0001000 : 7'b1111111;
            4'hB:    s = HEX_EN ? 7'b1100000 : 7'b1111111;
            4'hC:    s = HEX_EN ? 7'b0110001 : 7'b1111111;
            4'hD:    s = HEX_EN ? 7'b1000010 : 7'b1111111;
            4'hE:    s = HEX_EN ? 7'b0110000 : 7'b1111111;
            default: s = HEX_EN ? 7'b0111000 : 7'b1111111;
        endcase
        return s;
    endfunction

    // Scan counters
    always_comb begin
        p_last   = (p_q == PMax);
        idx_last = (idx_q == IdxMax);
        boundary = p_last && idx_last;
        p_d      = p_last ? '0 : p_q + PW'(1);
        idx_d    = idx_q;
        if (p_last) begin
            idx_d = idx_last ? '0 : idx_q + IW'(1);
        end
    end

    // Double buffer; a load on the boundary cycle bypasses the shadow straight to display
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp;
        end
        if (boundary) begin
            disp_val_d = load ? value : shadow_val_q;
            disp_dp_d  = load ? dp    : shadow_dp_q;
        end
    end

    // Current digit select; upper_zero tracks "this nibble and all above are zero"
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        an_sel     = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (disp_val_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                cur_nib   = disp_val_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                cur_blank = LZ_BLANK && (i != 0) && upper_zero;
                an_sel[i] = 1'b1;
            end
        end
    end

    // Registered pin drive; slot p=0 is the dark guard between digits
    always_comb begin
        lit          = enable && (p_q != '0);
        seg_n_d      = 7'h7F;
        dp_n_d       = 1'b1;
        an_n_d       = '1;
        frame_done_d = boundary;
        if (lit) begin
            an_n_d  = ~an_sel;
            dp_n_d  = ~cur_dp;
            seg_n_d = cur_blank ? 7'h7F : seg_decode(cur_nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q          <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            seg_n_q      <= 7'h7F;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
            frame_done_q <= 1'b0;
        end else begin
            p_q          <= p_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;

endmodule
